tcp_rx_slow_ctrl: RTL and testbench
===================================

TCP_RX_SLOW_CTRL -- requirements
Module: tcp_rx_slow_ctrl

Interface
REQ-001 SHALL have parameter PERF_CNT_W, default 32, width of each performance counter.
REQ-002 SHALL have port clk  in  1  sole clock.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port src_rx_hdr_val  in  1  header, IPs and payload entry valid at datapath inputs.
REQ-005 SHALL have port src_rx_hdr_rdy  out  1  header consumed this cycle.
REQ-006 SHALL have port src_rx_syn  in  1  SYN flag of the presented header.
REQ-007 SHALL have port flow_cam_hit  in  1  combinational CAM hit for the presented four-tuple.
REQ-008 SHALL have port flowid_mgr_req_val  out  1  request a free flowid.
REQ-009 SHALL have port flowid_mgr_req_rdy  in  1  free flowid available and granted on handshake.
REQ-010 SHALL have port state_rd_req_val  out  1  read rx/tx state and rx head/tail pointers.
REQ-011 SHALL have port state_rd_req_rdy  in  1  read accepted.
REQ-012 SHALL have port state_rd_resp_val  in  1  all read data valid.
REQ-013 SHALL have port state_wr_req_val  out  1  write next rx state, rx tail pointer and tx head pointer.
REQ-014 SHALL have port state_wr_req_rdy  in  1  write accepted.
REQ-015 SHALL have port sched_cmd_val  out  1  scheduler update command valid.
REQ-016 SHALL have port sched_cmd_rdy  in  1  scheduler accepted.
REQ-017 SHALL have port dst_val  out  1  payload-entry notification to the rx buffer consumer.
REQ-018 SHALL have port dst_rdy  in  1  consumer accepted.
REQ-019 SHALL have port new_flow_val  out  1  new-flow table init plus app notification valid.
REQ-020 SHALL have port new_flow_rdy  in  1  init accepted.
REQ-021 SHALL have port slow_path_enq_val  out  1  SYN-ACK enqueue valid.
REQ-022 SHALL have port slow_path_enq_rdy  in  1  enqueue accepted.
REQ-023 SHALL have ports ctrl_datap_save_input, ctrl_datap_save_flow_state, ctrl_datap_save_calcs, store_flowid_cam, store_flowid_manager  out  1 each  datapath load strobes.

Function
REQ-024 SHALL implement states READY, ALLOC, NEW_FLOW, RD_REQ, RD_WAIT, CALC, WRITE.
REQ-025 READY: src_rx_hdr_rdy=1; on src_rx_hdr_val, pulse save_input the same cycle and branch: hit -> store_flowid_cam, go RD_REQ; miss&SYN -> ALLOC; hit&SYN or miss&!SYN -> drop, stay READY.
REQ-026 ALLOC: flowid_mgr_req_val=1; on handshake pulse store_flowid_manager, go NEW_FLOW.
REQ-027 NEW_FLOW: assert new_flow_val and slow_path_enq_val together; each deasserts after its own handshake; return to READY when both are done, in either order or in the same cycle.
REQ-028 RD_REQ: state_rd_req_val=1 until handshake, then RD_WAIT; RD_WAIT: on state_rd_resp_val pulse save_flow_state, go CALC.
REQ-029 CALC: one cycle, pulse save_calcs, go WRITE.
REQ-030 WRITE: assert state_wr_req_val, sched_cmd_val and dst_val in parallel, each held until its own handshake; return to READY the cycle after the last completes; src_rx_hdr_rdy=0 until then.
REQ-031 All strobes SHALL be single-cycle; no strobe is asserted outside its state.
REQ-032 Minimum fast-path latency, header accept to READY, SHALL be 5 cycles with all rdy high and one-cycle read response.

Reset
REQ-033 rst_n low SHALL force READY, clear all done flags and counters, and drive every val and strobe output to 0 asynchronously, including mid-transaction; an in-flight packet is discarded.

Configuration
REQ-034 With TCP_RX_SLOW_CTRL_PERF_CNT_EN defined, SHALL add output perf_cnts, 3*PERF_CNT_W wide, holding {drops, new_flows, fast_path_pkts}, each saturating at all-ones; without the macro, the port and counters SHALL be absent.

Structure
REQ-035 State enum and perf-counter index constants SHALL live in tcp_misc_pkg; parallel-handshake completion tracking SHALL live in one sub-module, multi_hs_join.

Verification
REQ-036 Hit, non-SYN packet, all rdy high, 1-cycle response -> exact strobe sequence; READY re-entered 5 cycles after accept.
REQ-037 Miss+SYN, flowid_mgr_req_rdy low for 3 cycles -> store_flowid_manager on cycle 4; new_flow_val and slow_path_enq_val both seen.
REQ-038 In WRITE, dst_rdy delayed 4 cycles, others immediate -> no re-assertion of completed vals; READY after dst handshake.
REQ-039 Miss without SYN, and hit with SYN -> no downstream val; drop counter +1 each.
REQ-040 rst_n low during RD_WAIT -> all outputs 0 immediately; next packet processed normally.

Source files
------------

// File: rtl/tcp_misc_pkg.sv
// Shared definitions for the TCP receive control path: slow-control state encoding
// and the slot order of the optional performance counters (TCP_RX_SLOW_CTRL_PERF_CNT_EN).
package tcp_misc_pkg;

    typedef enum logic [2:0] {
        READY,
        ALLOC,
        NEW_FLOW,
        RD_REQ,
        RD_WAIT,
        CALC,
        WRITE
    } rx_slow_state_e;

    // Slot i of the packed counter bus sits at bits [i*W +: W].
    localparam int PERF_FAST_PATH_IDX = 0;
    localparam int PERF_NEW_FLOW_IDX  = 1;
    localparam int PERF_DROP_IDX      = 2;
    localparam int PERF_NUM_CNTS      = 3;

endpackage

// File: rtl/multi_hs_join.sv
// Joins N parallel valid/ready handshakes: each val drops after its own handshake,
// all_done fires in the cycle the last outstanding handshake completes.
module multi_hs_join #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         active,
    input  logic [N-1:0] rdy,
    output logic [N-1:0] val,
    output logic         all_done
);

    logic [N-1:0] done;

    assign val      = active ? ~done : '0;
    assign all_done = active && (&(done | (val & rdy)));

    // Flags clear on completion so the join is armed again for the next transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= '0;
        end else if (!active || all_done) begin
            done <= '0;
        end else begin
            done <= done | (val & rdy);
        end
    end

endmodule

// File: rtl/tcp_rx_slow_ctrl.sv
// Receive-path control FSM: classifies each header, runs flow allocation or the
// state read/calc/write fast path. Optional counters: TCP_RX_SLOW_CTRL_PERF_CNT_EN.
module tcp_rx_slow_ctrl
    import tcp_misc_pkg::*;
#(
    parameter int PERF_CNT_W = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic src_rx_hdr_val,
    output logic src_rx_hdr_rdy,
    input  logic src_rx_syn,
    input  logic flow_cam_hit,
    output logic flowid_mgr_req_val,
    input  logic flowid_mgr_req_rdy,
    output logic state_rd_req_val,
    input  logic state_rd_req_rdy,
    input  logic state_rd_resp_val,
    output logic state_wr_req_val,
    input  logic state_wr_req_rdy,
    output logic sched_cmd_val,
    input  logic sched_cmd_rdy,
    output logic dst_val,
    input  logic dst_rdy,
    output logic new_flow_val,
    input  logic new_flow_rdy,
    output logic slow_path_enq_val,
    input  logic slow_path_enq_rdy,
    output logic ctrl_datap_save_input,
    output logic ctrl_datap_save_flow_state,
    output logic ctrl_datap_save_calcs,
    output logic store_flowid_cam,
    output logic store_flowid_manager
`ifdef TCP_RX_SLOW_CTRL_PERF_CNT_EN
    ,
    output logic [3*PERF_CNT_W-1:0] perf_cnts
`endif
);

    rx_slow_state_e state;
    logic           fast_hit;
    logic           new_syn;
    logic [1:0]     nf_val;
    logic [2:0]     wr_val;
    logic           nf_done;
    logic           wr_done;

    assign fast_hit = flow_cam_hit && !src_rx_syn;
    assign new_syn  = !flow_cam_hit && src_rx_syn;

    multi_hs_join #(.N(2)) u_new_flow_join (
        .clk      (clk),
        .rst_n    (rst_n),
        .active   (rst_n && (state == NEW_FLOW)),
        .rdy      ({slow_path_enq_rdy, new_flow_rdy}),
        .val      (nf_val),
        .all_done (nf_done)
    );

    multi_hs_join #(.N(3)) u_write_join (
        .clk      (clk),
        .rst_n    (rst_n),
        .active   (rst_n && (state == WRITE)),
        .rdy      ({dst_rdy, sched_cmd_rdy, state_wr_req_rdy}),
        .val      (wr_val),
        .all_done (wr_done)
    );

    assign new_flow_val      = nf_val[0];
    assign slow_path_enq_val = nf_val[1];
    assign state_wr_req_val  = wr_val[0];
    assign sched_cmd_val     = wr_val[1];
    assign dst_val           = wr_val[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= READY;
        end else begin
            case (state)
                READY: begin
                    if (src_rx_hdr_val && fast_hit) begin
                        state <= RD_REQ;
                    end else if (src_rx_hdr_val && new_syn) begin
                        state <= ALLOC;
                    end
                end
                ALLOC:    if (flowid_mgr_req_rdy) state <= NEW_FLOW;
                NEW_FLOW: if (nf_done) state <= READY;
                RD_REQ:   if (state_rd_req_rdy) state <= RD_WAIT;
                RD_WAIT:  if (state_rd_resp_val) state <= CALC;
                CALC:     state <= WRITE;
                WRITE:    if (wr_done) state <= READY;
                default:  state <= READY;
            endcase
        end
    end

    // Strobes follow the handshake in the same cycle; reset gates them off immediately.
    always_comb begin
        src_rx_hdr_rdy             = 1'b0;
        flowid_mgr_req_val         = 1'b0;
        state_rd_req_val           = 1'b0;
        ctrl_datap_save_input      = 1'b0;
        ctrl_datap_save_flow_state = 1'b0;
        ctrl_datap_save_calcs      = 1'b0;
        store_flowid_cam           = 1'b0;
        store_flowid_manager       = 1'b0;
        if (rst_n) begin
            case (state)
                READY: begin
                    src_rx_hdr_rdy        = 1'b1;
                    ctrl_datap_save_input = src_rx_hdr_val;
                    store_flowid_cam      = src_rx_hdr_val && fast_hit;
                end
                ALLOC: begin
                    flowid_mgr_req_val   = 1'b1;
                    store_flowid_manager = flowid_mgr_req_rdy;
                end
                RD_REQ:  state_rd_req_val = 1'b1;
                RD_WAIT: ctrl_datap_save_flow_state = state_rd_resp_val;
                CALC:    ctrl_datap_save_calcs = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef TCP_RX_SLOW_CTRL_PERF_CNT_EN
    logic [PERF_CNT_W-1:0]    cnt [PERF_NUM_CNTS];
    logic [PERF_NUM_CNTS-1:0] cnt_evt;

    assign cnt_evt[PERF_FAST_PATH_IDX] = wr_done;
    assign cnt_evt[PERF_NEW_FLOW_IDX]  = nf_done;
    assign cnt_evt[PERF_DROP_IDX]      = (state == READY) && src_rx_hdr_val && !fast_hit && !new_syn;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PERF_NUM_CNTS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < PERF_NUM_CNTS; i++) begin
                if (cnt_evt[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + PERF_CNT_W'(1);
            end
        end
    end

    always_comb begin
        perf_cnts = '0;
        for (int i = 0; i < PERF_NUM_CNTS; i++) perf_cnts[i*PERF_CNT_W +: PERF_CNT_W] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_tcp_rx_slow_ctrl.sv
// Randomized bench for tcp_rx_slow_ctrl: per-packet latency, strobe timing and
// handshake counts predicted from channel delays; counters under TCP_RX_SLOW_CTRL_PERF_CNT_EN.
module tb_tcp_rx_slow_ctrl;

    localparam int PERF_CNT_W = 8;
    localparam int CYC_LIMIT  = 200;
    localparam int CH_MGR = 0, CH_RD = 1, CH_WR = 2, CH_SCH = 3, CH_DST = 4, CH_NF = 5, CH_SPE = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       src_rx_hdr_val = 1'b0;
    logic       src_rx_syn = 1'b0;
    logic       flow_cam_hit = 1'b0;
    logic       state_rd_resp_val = 1'b0;
    logic [6:0] rdy_v = '0;

    logic src_rx_hdr_rdy, flowid_mgr_req_val, state_rd_req_val, state_wr_req_val;
    logic sched_cmd_val, dst_val, new_flow_val, slow_path_enq_val;
    logic ctrl_datap_save_input, ctrl_datap_save_flow_state, ctrl_datap_save_calcs;
    logic store_flowid_cam, store_flowid_manager;
`ifdef TCP_RX_SLOW_CTRL_PERF_CNT_EN
    logic [3*PERF_CNT_W-1:0] perf_cnts;
`endif

    int checks = 0;
    int errors = 0;
    int exp_fast = 0;
    int exp_new = 0;
    int exp_drop = 0;

    wire [6:0] val_v = {slow_path_enq_val, new_flow_val, dst_val, sched_cmd_val,
                        state_wr_req_val, state_rd_req_val, flowid_mgr_req_val};
    wire [11:0] out_vec = {val_v, ctrl_datap_save_input, ctrl_datap_save_flow_state,
                           ctrl_datap_save_calcs, store_flowid_cam, store_flowid_manager};

    tcp_rx_slow_ctrl #(.PERF_CNT_W(PERF_CNT_W)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .src_rx_hdr_val             (src_rx_hdr_val),
        .src_rx_hdr_rdy             (src_rx_hdr_rdy),
        .src_rx_syn                 (src_rx_syn),
        .flow_cam_hit               (flow_cam_hit),
        .flowid_mgr_req_val         (flowid_mgr_req_val),
        .flowid_mgr_req_rdy         (rdy_v[CH_MGR]),
        .state_rd_req_val           (state_rd_req_val),
        .state_rd_req_rdy           (rdy_v[CH_RD]),
        .state_rd_resp_val          (state_rd_resp_val),
        .state_wr_req_val           (state_wr_req_val),
        .state_wr_req_rdy           (rdy_v[CH_WR]),
        .sched_cmd_val              (sched_cmd_val),
        .sched_cmd_rdy              (rdy_v[CH_SCH]),
        .dst_val                    (dst_val),
        .dst_rdy                    (rdy_v[CH_DST]),
        .new_flow_val               (new_flow_val),
        .new_flow_rdy               (rdy_v[CH_NF]),
        .slow_path_enq_val          (slow_path_enq_val),
        .slow_path_enq_rdy          (rdy_v[CH_SPE]),
        .ctrl_datap_save_input      (ctrl_datap_save_input),
        .ctrl_datap_save_flow_state (ctrl_datap_save_flow_state),
        .ctrl_datap_save_calcs      (ctrl_datap_save_calcs),
        .store_flowid_cam           (store_flowid_cam),
        .store_flowid_manager       (store_flowid_manager)
`ifdef TCP_RX_SLOW_CTRL_PERF_CNT_EN
        ,
        .perf_cnts                  (perf_cnts)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int sat(input int x);
        int top;
        top = (1 << PERF_CNT_W) - 1;
        return (x > top) ? top : x;
    endfunction

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkPerf();
`ifdef TCP_RX_SLOW_CTRL_PERF_CNT_EN
        checkOutput("perf_fast_path", int'(perf_cnts[0 +: PERF_CNT_W]), sat(exp_fast));
        checkOutput("perf_new_flows", int'(perf_cnts[PERF_CNT_W +: PERF_CNT_W]), sat(exp_new));
        checkOutput("perf_drops", int'(perf_cnts[2*PERF_CNT_W +: PERF_CNT_W]), sat(exp_drop));
`endif
    endtask

    // One packet from header accept back to READY; each responder raises rdy after
    // seeing its val for dly cycles, the read response arrives d_resp cycles after the request.
    task automatic applyStimulus(input bit hit, input bit syn, input int d_mgr, input int d_rd,
                                 input int d_resp, input int d_wr, input int d_sch, input int d_dst,
                                 input int d_nf, input int d_spe);
        int dly[7];
        int hs[7];
        int valcyc[7];
        int waitc[7];
        bit part[7];
        int cyc, ready_at, rd_hs_cyc, exp_lat;
        int n_si, n_cam, n_mgr, n_fs, n_calc, t_mgr, t_fs, t_calc;
        bit fast, newf, finished;

        dly = '{d_mgr, d_rd, d_wr, d_sch, d_dst, d_nf, d_spe};
        for (int c = 0; c < 7; c++) begin
            hs[c] = 0; valcyc[c] = 0; waitc[c] = 0;
        end
        fast = hit && !syn;
        newf = !hit && syn;
        part = '{newf, fast, fast, fast, fast, newf, newf};
        n_si = 0; n_cam = 0; n_mgr = 0; n_fs = 0; n_calc = 0;
        t_mgr = -1; t_fs = -1; t_calc = -1;
        cyc = 0; ready_at = -1; rd_hs_cyc = -1; finished = 1'b0;

        src_rx_hdr_val = 1'b1;
        flow_cam_hit   = hit;
        src_rx_syn     = syn;
        while (!finished && cyc < CYC_LIMIT) begin
            if (cyc == 1) src_rx_hdr_val = 1'b0;
            #1;
            for (int c = 0; c < 7; c++) rdy_v[c] = val_v[c] && (waitc[c] >= dly[c]);
            state_rd_resp_val = (rd_hs_cyc >= 0) && (cyc >= rd_hs_cyc + 1 + d_resp) && (n_fs == 0);
            #1;
            for (int c = 0; c < 7; c++) begin
                valcyc[c] += int'(val_v[c]);
                waitc[c]  += int'(val_v[c]);
                if (val_v[c] && rdy_v[c]) begin
                    hs[c]++;
                    if (c == CH_RD) rd_hs_cyc = cyc;
                end
            end
            if (ctrl_datap_save_input) n_si++;
            if (store_flowid_cam) n_cam++;
            if (store_flowid_manager) begin n_mgr++; t_mgr = cyc; end
            if (ctrl_datap_save_flow_state) begin n_fs++; t_fs = cyc; end
            if (ctrl_datap_save_calcs) begin n_calc++; t_calc = cyc; end
            if (cyc > 0 && src_rx_hdr_rdy) begin
                ready_at = cyc;
                finished = 1'b1;
            end else begin
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
        end
        rdy_v = '0;
        state_rd_resp_val = 1'b0;
        src_rx_hdr_val = 1'b0;

        if (!finished) begin
            checkOutput("ready_return_timeout", 0, 1);
            rst_n = 1'b0;
            exp_fast = 0; exp_new = 0; exp_drop = 0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            return;
        end

        if (fast)      exp_lat = 5 + d_rd + d_resp + max2(d_wr, max2(d_sch, d_dst));
        else if (newf) exp_lat = 3 + d_mgr + max2(d_nf, d_spe);
        else           exp_lat = 1;
        checkOutput("accept_to_ready", ready_at, exp_lat);
        checkOutput("save_input_cnt", n_si, 1);
        checkOutput("store_flowid_cam_cnt", n_cam, int'(fast));
        checkOutput("store_flowid_mgr_cnt", n_mgr, int'(newf));
        checkOutput("save_flow_state_cnt", n_fs, int'(fast));
        checkOutput("save_calcs_cnt", n_calc, int'(fast));
        if (fast) begin
            checkOutput("save_flow_state_cyc", t_fs, 2 + d_rd + d_resp);
            checkOutput("save_calcs_cyc", t_calc, 3 + d_rd + d_resp);
        end
        if (newf) checkOutput("store_flowid_mgr_cyc", t_mgr, 1 + d_mgr);
        for (int c = 0; c < 7; c++) begin
            checkOutput($sformatf("ch%0d_handshakes", c), hs[c], part[c] ? 1 : 0);
            checkOutput($sformatf("ch%0d_val_cycles", c), valcyc[c], part[c] ? dly[c] + 1 : 0);
        end

        if (fast)      exp_fast++;
        else if (newf) exp_new++;
        else           exp_drop++;
        checkPerf();
        @(negedge clk);
    endtask

    initial begin
        bit h, s;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_vals_strobes", int'(out_vec), 0);
        checkOutput("reset_hdr_rdy", int'(src_rx_hdr_rdy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("idle_hdr_rdy", int'(src_rx_hdr_rdy), 1);
        checkOutput("idle_vals_strobes", int'(out_vec), 0);
        checkPerf();
        @(negedge clk);

        applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 3, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 0, 4, 0, 0);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 2, 0);
        applyStimulus(1'b0, 1'b1, 1, 0, 0, 0, 0, 0, 0, 3);
        applyStimulus(1'b1, 1'b0, 0, 2, 3, 1, 3, 0, 0, 0);

        // Reset while waiting for the read response, with a header pending at the input.
        src_rx_hdr_val = 1'b1; flow_cam_hit = 1'b1; src_rx_syn = 1'b0;
        @(negedge clk);
        src_rx_hdr_val = 1'b0;
        rdy_v[CH_RD] = 1'b1;
        @(negedge clk);
        rdy_v = '0;
        #1;
        checkOutput("rd_wait_hdr_rdy", int'(src_rx_hdr_rdy), 0);
        src_rx_hdr_val = 1'b1;
        state_rd_resp_val = 1'b1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs", int'(out_vec), 0);
        exp_fast = 0; exp_new = 0; exp_drop = 0;
        @(negedge clk);
        src_rx_hdr_val = 1'b0;
        state_rd_resp_val = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checkPerf();
        applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 60; k++) begin
            h = ($urandom_range(0, 1) == 1);
            s = ($urandom_range(0, 1) == 1);
            applyStimulus(h, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
                          $urandom_range(0, 3), $urandom_range(0, 3));
        end

`ifdef TCP_RX_SLOW_CTRL_PERF_CNT_EN
        for (int k = 0; k < 260; k++) applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
